serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and result width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled on the rising edge of clk.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects a+b+cin; 1 selects a-b, with cin ignored.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result becomes valid.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result register.
REQ-012 The block SHALL have port cout, output, 1 bit: final carry-out; for subtraction 1 = no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the result.

Function
REQ-014 The block SHALL instantiate exactly one 1-bit full adder (full_adder: a, b, c -> sum, carry) and compute all results bit-serially through it, LSB first.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE; it leaves reset in IDLE.
REQ-016 In IDLE, start=1 at a clock edge SHALL capture a, b (inverted when sub=1), sub and the initial carry (cin when sub=0, 1 when sub=1), clear the bit counter, and move the FSM to RUN.
REQ-017 In RUN, each cycle SHALL feed operand bit i and the carry register to the full adder, store the sum bit at position i of an internal shift register, update the carry register, and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the WIDTH-th edge after the capture edge, the FSM SHALL move to DONE.
REQ-019 On that same WIDTH-th edge, sum, cout and ovf SHALL be loaded.
- ovf = carry into MSB XOR carry out of MSB.
REQ-020 busy SHALL be 1 from the capture edge up to the WIDTH-th edge, and 0 otherwise.
REQ-021 done SHALL be 1 only in the DONE state, i.e. for exactly one cycle; DONE SHALL always return to IDLE on the next edge.
REQ-022 sum, cout and ovf SHALL hold their last values until the next completion; they SHALL NOT change during RUN.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing; a, b, cin and sub SHALL be don't-care outside the capture edge.
REQ-024 Back-to-back operation: start held high SHALL begin a new operation on the edge after DONE (IDLE capture), giving one result every WIDTH+2 cycles.
REQ-025 With WIDTH=1, RUN SHALL last one cycle and all rules above SHALL still hold.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force the FSM to IDLE and busy, done, sum, cout, ovf, the counter, the carry register and the shift register to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and no partial result visible.
REQ-029 Reset release SHALL be synchronous to clk; the first start can be captured on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-030 Scenario: a=8'h0F, b=8'h01, cin=0, sub=0, start pulse -> busy high for 8 cycles, then done pulse; sum=8'h10, cout=0, ovf=0.
REQ-031 Scenario: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-032 Scenario: sub=1, a=8'h05, b=8'h07, cin=1 -> sum=8'hFE, cout=0, ovf=0; sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-033 Scenario: start pulsed again on cycle 3 of RUN with different operands -> ignored; the first result is unchanged and there is exactly one done pulse.
REQ-034 Scenario: rst_n low for 1 cycle on cycle 4 of RUN -> all outputs 0 immediately, no done pulse; a following start of 8'h01+8'h01 -> sum=8'h02.
REQ-035 Scenario: start held high continuously -> done pulses exactly every 10 cycles; sum stays stable between pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder processes one operand bit per
// clock, LSB first; results are published in a single edge at completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  // Counter reaches WIDTH on the final edge, so it needs one value beyond
  // the bit index range; the index itself is the truncated counter.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, shreg, sh_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             fa_sum, fa_carry;
  logic             last;

  assign idx  = cnt[IW-1:0];
  assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));

  full_adder u_fa (
    .a     (a_reg[idx]),
    .b     (b_reg[idx]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // NOTE: default assignment first so no path leaves sh_next unassigned (no latch).
  always_comb begin
    sh_next      = shreg;
    sh_next[idx] = fa_sum;
  end

  // NOTE: all sequential state uses non-blocking assignments to avoid update-order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      shreg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        // Subtraction is a + ~b + 1; cin is irrelevant in that mode.
        a_reg <= a;
        b_reg <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        shreg <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        shreg <= sh_next;
        carry <= fa_carry;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= sh_next;
          cout <= fa_carry;
          ovf  <= carry ^ fa_carry;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: latency, arithmetic corner
// cases, start masking, mid-run reset and back-to-back throughput.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation from IDLE: counts busy cycles, checks the result on the
  // done cycle, then confirms done lasts a single cycle.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic c,
                        input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    int nbusy = 0;
    int n = 0;
    @(negedge clk);
    sub = s; a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hA5; b = 8'h5A; cin = ~c; sub = ~s;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, want done=1", name, done, n);
    end
    vectors++;
    if (nbusy != W) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", name, nbusy, W);
    end
    vectors++;
    if ({sum, cout, ovf} !== {exp_sum, exp_cout, exp_ovf}) begin
      miscompares++;
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_after_done: got done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_arith();
    run_op("add_0f_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_cin",   1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
    run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    @(negedge clk);
    sub = 1'b0; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h55; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      if (done) ndone++;
      @(negedge clk);
    end
    vectors++;
    if (ndone != 1) begin
      miscompares++;
      $display("FAIL ignore_start_done_count: got %0d, want 1", ndone);
    end
    vectors++;
    if (sum !== 8'h30) begin
      miscompares++;
      $display("FAIL ignore_start_sum: got %h, want 30", sum);
    end
  endtask

  task automatic test_mid_reset();
    int ndone = 0;
    @(negedge clk);
    sub = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    vectors++;
    if (ndone != 0 || sum !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_no_result: got %0d busy/done cycles sum=%h, want 0 and 00", ndone, sum);
    end
    run_op("after_reset", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int gap;
    logic stable;
    @(negedge clk);
    sub = 1'b0; a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL b2b_first_done: no done within %0d cycles, want one", n);
    end
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      stable = 1'b1;
      do begin
        @(negedge clk);
        gap++;
        if (!done && sum !== 8'h07) stable = 1'b0;
      end while (!done && gap < 20);
      vectors++;
      if (gap != W + 2) begin
        miscompares++;
        $display("FAIL b2b_period_%0d: got %0d cycles, want %0d", p, gap, W + 2);
      end
      vectors++;
      if (!stable || sum !== 8'h07) begin
        miscompares++;
        $display("FAIL b2b_sum_%0d: stable=%b sum=%h, want stable=1 sum=07", p, stable, sum);
      end
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
